// File: rtl/shift_reg_n.sv
// shift_reg_n: parametrised bidirectional shift register.
// Single-step mode: load, hold, clear, logical/rotate/arithmetic shifts, one
// bit per enabled cycle. Multi-step mode: an internal IDLE/RUN FSM repeats a
// shift op amt times, with a busy flag and a one-cycle done pulse.
module shift_reg_n #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic             sd,
    input  logic             start,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             so,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SLL  = 3'b010,
        OP_SRL  = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101,
        OP_SRA  = 3'b110,
        OP_CLR  = 3'b111
    } op_t;

    state_t           state;
    op_t              op_r;
    logic [AMT_W-1:0] cnt;

    op_t              cur_op;
    logic [WIDTH-1:0] nq;
    logic             nso;
    logic             is_multi;

    // Only the five shift/rotate ops may run as a multi-step sequence.
    assign is_multi = (op >= 3'b010) && (op <= 3'b110);

    // Next q/so for one step; in RUN the latched op is used, so op is ignored.
    always_comb begin
        cur_op = (state == RUN) ? op_r : op_t'(op);
        nq     = q;
        nso    = so;
        case (cur_op)
            OP_HOLD: ;
            OP_LOAD: nq = d;
            OP_SLL: begin
                nq  = {q[WIDTH-2:0], sd};
                nso = q[WIDTH-1];
            end
            OP_SRL: begin
                nq  = {sd, q[WIDTH-1:1]};
                nso = q[0];
            end
            OP_ROL: begin
                nq  = {q[WIDTH-2:0], q[WIDTH-1]};
                nso = q[WIDTH-1];
            end
            OP_ROR: begin
                nq  = {q[0], q[WIDTH-1:1]};
                nso = q[0];
            end
            OP_SRA: begin
                nq  = {q[WIDTH-1], q[WIDTH-1:1]};
                nso = q[0];
            end
            OP_CLR: begin
                nq  = '0;
                nso = 1'b0;
            end
            default: ;
        endcase
    end

    // Register, FSM and handshake update; done defaults low so it pulses once.
    always_ff @(posedge clk) begin
        if (reset) begin
            q     <= '0;
            so    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            state <= IDLE;
            op_r  <= OP_HOLD;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        if (start && is_multi) begin
                            if (amt != '0) begin
                                op_r  <= op_t'(op);
                                cnt   <= amt;
                                busy  <= 1'b1;
                                state <= RUN;
                            end else begin
                                done <= 1'b1;
                            end
                        end else begin
                            q  <= nq;
                            so <= nso;
                        end
                    end
                end
                RUN: begin
                    if (en) begin
                        q   <= nq;
                        so  <= nso;
                        cnt <= cnt - AMT_W'(1);
                        if (cnt == AMT_W'(1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/shift_reg_n.md
Name: shift_reg_n

Overview:
Parametrised successor to the team's 8-bit bidirectional shifter. Provides load, hold and clear, plus logical, rotate and arithmetic shifts, in two forms: one bit per enabled cycle, or a multi-step shift of a programmable amount run by an internal FSM with busy/done handshake. It sits in datapath/serial-conversion paths wherever a shifter of arbitrary width is needed.

Parameters:
WIDTH, 8, data width in bits; must be >= 2
AMT_W, 4, width of shift-amount input; max multi-step amount 2**AMT_W-1

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
en  in  1  operation enable; in RUN, 0 stalls the sequence
op  in  3  000 hold, 001 load d, 010 shift left logical, 011 shift right logical, 100 rotate left, 101 rotate right, 110 arithmetic shift right, 111 clear
sd  in  1  serial data in; fills the vacated bit for 010/011
start  in  1  request multi-step shift of amt steps (IDLE only)
amt  in  AMT_W  multi-step shift count
d  in  WIDTH  parallel load data
q  out  WIDTH  register contents
so  out  1  bit shifted/rotated out by the most recent step
busy  out  1  high while multi-step sequence running
done  out  1  one-cycle pulse at multi-step completion

Behaviour:
- Clock and reset: all state updates on rising clk. Reset is synchronous and active-high, and overrides everything.
- Reset values: q=0, so=0, busy=0, done=0, FSM=IDLE, step counter=0.
- Single step, one bit per enabled cycle: IDLE, en=1, and either start=0 or op in {000,001,111}:
  - op executes once at that edge.
  - 010: q<={q[W-2:0],sd}, so<=q[W-1].
  - 011: q<={sd,q[W-1:1]}, so<=q[0].
  - 100: q<={q[W-2:0],q[W-1]}, so<=q[W-1].
  - 101: q<={q[0],q[W-1:1]}, so<=q[0].
  - 110: q<={q[W-1],q[W-1:1]}, so<=q[0]; sd ignored.
  - 001: q<=d, so unchanged. 000: no change. 111: q<=0, so<=0.
  - busy/done stay 0.
- en=0 in IDLE: q and so hold; start is ignored.
- FSM states: IDLE, RUN.
- Start accept: IDLE, en=1, start=1, op in {010..110}.
  - amt>0: latch op into op_r and amt into counter; busy<=1; q unchanged at the accepting edge; FSM goes to RUN.
  - amt=0: q unchanged, busy stays 0, done<=1 for one cycle, FSM stays IDLE.
- RUN:
  - Each edge with en=1 performs one op_r step using the current sd, and decrements the counter.
  - Edge with en=0: q, so and counter hold; busy stays 1.
  - On the step that takes the counter 1->0: busy<=0, done<=1, FSM goes to IDLE.
  - Latency: busy is high for exactly amt enabled cycles after the accepting edge. done is high in the cycle following the last step, with final q valid in that same cycle.
  - op, d, start and amt are ignored in RUN. start pulses in RUN are dropped, not queued.
- done: high for exactly one cycle and never coincides with busy. A start accepted in the cycle where done=1 is legal (back-to-back).
- Reset mid-RUN: abort; all outputs return to reset values next cycle; done is not pulsed.
- amt greater than WIDTH is legal: the FSM performs amt single-bit steps; rotates wrap, logical shifts fill with sd.

Test Plan:
1. Reset, then IDLE en=1 op=001 d=8'h0F -> q=8'h0F, so=0, busy=0, done=0.
2. From q=0F: op=010 sd=1 one cycle -> q=8'h1F, so=0. Then op=011 sd=0 -> q=8'h0F, so=1. Then en=0 with op=010 -> q holds 0F.
3. q=8'h81, start=1 op=101 amt=3 -> busy high 3 cycles, q=C0, 60, 30; done=1 one cycle with q=8'h30, so=0; busy=0.
4. q=8'h90, start op=110 amt=2 -> q=C8 then E4, done pulse. Back-to-back: start op=100 amt=1 during the done cycle -> q=8'hC9, so=1, second done pulse.
5. q=8'h01, start op=100 amt=4, en=0 for 2 cycles after the first step -> q holds 02 while busy=1. Resume -> q=04, 08, 10, then done. Rerun the same sequence with reset=1 mid-RUN -> q=0, busy=0, no done.
6. start=1 op=011 amt=0 -> done=1 for one cycle, busy never asserts, q unchanged. start=1 op=001 -> treated as a plain load, no busy, no done.
